// File: rtl/data_ram_pkg.sv
// Shared definitions for the data_ram block: FSM state encoding, default
// parameter values and the word-index geometry.
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_LATENCY    = 3;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 8;

    // Word index is address[DEPTH_LOG2+1:WORD_LSB]; its width equals DEPTH_LOG2.
    localparam int unsigned WORD_LSB      = 2;
    localparam int unsigned DEFAULT_IDX_W = DEFAULT_DEPTH_LOG2;

    // Latency counter width; covers LATENCY-1 for LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/data_ram_array.sv
// 32-bit word storage for data_ram: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];

    // Store the word on the clock edge when the write is enabled
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_ram.sv
// data_ram: fixed-latency 32-bit word RAM with read/write strobes and
// one-cycle completion pulses. Optional err output enabled by the
// DATA_RAM_ERR_EN macro.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        nRD,
    input  logic        nWR,
`ifdef DATA_RAM_ERR_EN
    output logic        err,
`endif
    output logic [31:0] Dataout,
    output logic        readStatus,
    output logic        writeStatus,
    output logic        busy
);

    localparam int unsigned IDX_W = DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata;
    logic             commit;
    logic [IDX_W-1:0] req_idx;

    assign req_idx = address[IDX_W+WORD_LSB-1:WORD_LSB];

`ifdef DATA_RAM_ERR_EN
    logic err_flag_q;
    logic addr_err;
    assign addr_err = (address[31:IDX_W+WORD_LSB] != '0) || (address[WORD_LSB-1:0] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:IDX_W+WORD_LSB], address[WORD_LSB-1:0]};
`endif

    // Write lands in the array only on the WR_WAIT completion edge, so a reset
    // during the wait leaves the array untouched.
    assign commit = (state_q == WR_WAIT) && (cnt_q == '0);
    assign busy   = (state_q != IDLE);

    data_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (clk),
        .we_i    (commit),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    // Request FSM: accept in IDLE, count down latency, pulse status on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            Dataout     <= '0;
            readStatus  <= 1'b0;
            writeStatus <= 1'b0;
`ifdef DATA_RAM_ERR_EN
            err_flag_q  <= 1'b0;
            err         <= 1'b0;
`endif
        end else begin
            readStatus  <= 1'b0;
            writeStatus <= 1'b0;
`ifdef DATA_RAM_ERR_EN
            err         <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (!nRD) begin
                        state_q <= RD_WAIT;
                        cnt_q   <= CNT_LOAD;
                        idx_q   <= req_idx;
`ifdef DATA_RAM_ERR_EN
                        err_flag_q <= addr_err || !nWR;
`endif
                    end else if (!nWR) begin
                        state_q <= WR_WAIT;
                        cnt_q   <= CNT_LOAD;
                        idx_q   <= req_idx;
                        wdata_q <= writeData;
`ifdef DATA_RAM_ERR_EN
                        err_flag_q <= addr_err;
`endif
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        readStatus <= 1'b1;
                        Dataout    <= rdata;
`ifdef DATA_RAM_ERR_EN
                        err        <= err_flag_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        writeStatus <= 1'b1;
`ifdef DATA_RAM_ERR_EN
                        err         <= err_flag_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Testbench for data_ram: directed scenarios followed by random strobes,
// checked against a transaction-level reference model.
module tb_data_ram;

    localparam int unsigned LAT   = 3;
    localparam int unsigned DL2   = 8;
    localparam int unsigned DEPTH = 1 << DL2;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        nRD;
    logic        nWR;
    logic [31:0] Dataout;
    logic        readStatus;
    logic        writeStatus;
    logic        busy;
`ifdef DATA_RAM_ERR_EN
    logic        err;
`endif

    data_ram #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .writeData   (writeData),
        .nRD         (nRD),
        .nWR         (nWR),
`ifdef DATA_RAM_ERR_EN
        .err         (err),
`endif
        .Dataout     (Dataout),
        .readStatus  (readStatus),
        .writeStatus (writeStatus),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a request accepted at edge T completes at edge T+LAT.
    logic [31:0] mem_m [int unsigned];
    int          edge_n;
    bit          pend, pend_rd, pend_err;
    int          done_edge;
    int unsigned pend_idx;
    logic [31:0] pend_data;
    logic [31:0] exp_dout;
    bit          dout_known;
    bit          exp_rs, exp_ws, exp_err;

    task automatic model_reset();
        pend = 0; exp_dout = '0; dout_known = 1;
        exp_rs = 0; exp_ws = 0; exp_err = 0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_rs = 0; exp_ws = 0; exp_err = 0;
        if (pend) begin
            if (edge_n == done_edge) begin
                pend    = 0;
                exp_err = pend_err;
                if (pend_rd) begin
                    exp_rs = 1;
                    if (mem_m.exists(pend_idx)) begin
                        exp_dout = mem_m[pend_idx]; dout_known = 1;
                    end else begin
                        dout_known = 0;
                    end
                end else begin
                    exp_ws = 1;
                    mem_m[pend_idx] = pend_data;
                end
            end
        end else if (rd || wr) begin
            pend      = 1;
            pend_rd   = rd;
            pend_idx  = (a / 4) % DEPTH;
            pend_data = d;
            pend_err  = (a >= 4 * DEPTH) || (a % 4 != 0) || (rd && wr);
            done_edge = edge_n + LAT;
        end
        edge_n++;
    endtask

    task automatic compare_outputs();
        check("readStatus", {31'b0, readStatus}, {31'b0, exp_rs});
        check("writeStatus", {31'b0, writeStatus}, {31'b0, exp_ws});
        check("busy", {31'b0, busy}, {31'b0, pend});
        if (dout_known) check("Dataout", Dataout, exp_dout);
`ifdef DATA_RAM_ERR_EN
        check("err", {31'b0, err}, {31'b0, exp_err});
`endif
    endtask

    task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        nRD = ~rd; nWR = ~wr; address = a; writeData = d;
        @(posedge clk);
        model_edge(rd, wr, a, d);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0);
    endtask

    // Request followed by enough idle cycles to complete it
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        step(rd, wr, a, d);
        idle(LAT);
    endtask

    // Assert reset away from the clock edge, check outputs clear at once,
    // release just after a rising edge so the next edge is the first one out of reset
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; nRD = 1'b1; nWR = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_readStatus", {31'b0, readStatus}, 32'd0);
        check("rst_writeStatus", {31'b0, writeStatus}, 32'd0);
        check("rst_Dataout", Dataout, 32'd0);
`ifdef DATA_RAM_ERR_EN
        check("rst_err", {31'b0, err}, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; nRD = 1'b1; nWR = 1'b1; address = '0; writeData = '0;
        edge_n = 0;
        model_reset();
        #2;
        do_reset();

        // Write then read back at 0x10; first write accepted on first edge out of reset
        txn(0, 1, 32'h10, 32'hDEADBEEF);
        txn(1, 0, 32'h10, 32'h0);
        check("dout_beef", Dataout, 32'hDEADBEEF);
        idle(2);
        check("dout_held", Dataout, 32'hDEADBEEF);

        // Simultaneous read+write at 0x20: read wins, word 8 unchanged
        txn(0, 1, 32'h20, 32'h12345678);
        txn(1, 1, 32'h20, 32'h1);
        txn(1, 0, 32'h20, 32'h0);
        check("word8_kept", Dataout, 32'h12345678);

        // Strobes while busy and on the completion edge are ignored
        step(1, 0, 32'h10, 32'h0);
        step(1, 0, 32'h20, 32'h0);
        step(0, 1, 32'h20, 32'h0);
        step(1, 0, 32'h20, 32'h0);
        idle(LAT + 1);
        check("busy_read_ignored", Dataout, 32'hDEADBEEF);

        // Reset mid write: no pulse, array keeps prior contents
        txn(0, 1, 32'h30, 32'hCAFE0001);
        step(0, 1, 32'h30, 32'hBAD0BAD0);
        idle(1);
        do_reset();
        idle(LAT);
        txn(1, 0, 32'h30, 32'h0);
        check("abort_write", Dataout, 32'hCAFE0001);

        // Reset mid read: no read pulse
        step(1, 0, 32'h30, 32'h0);
        do_reset();
        idle(LAT + 1);

        // Out-of-range address wraps onto word 0
        txn(0, 1, 32'h400, 32'h55);
        txn(1, 0, 32'h0, 32'h0);
        check("wrap_read", Dataout, 32'h55);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 149) == 0) do_reset();
            else step(r < 2 || r == 4, (r >= 2 && r < 4) || r == 4, a, $urandom);
        end
        idle(LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
